id_digit_sequencer: RTL and testbench
=====================================

ID_DIGIT_SEQUENCER -- requirements
Module: id_digit_sequencer

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of ID digits in the sequence (2..16).
REQ-002 Parameter ID_BCD, default 32'h12345678, packed ID nibbles, width 4*NUM_DIGITS, digit 0 = most-significant nibble.
REQ-003 Parameter HOLD_TICKS, default 2, ticks each digit stays lit before blanking (1..15).
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high; clears all state.
REQ-006 tick  input  1  one-cycle pulse from the 1 s rollover timer; the only pacing source.
REQ-007 start  input  1  level-sampled; begins or resumes sequencing.
REQ-008 stop  input  1  level-sampled; pauses sequencing.
REQ-009 step  input  1  one-cycle pulse; manual advance while paused.
REQ-010 digit_idx  output  4  index of current digit.
REQ-011 bcd  output  4  nibble of current digit.
REQ-012 seg_n  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-013 running  output  1  high in SHOW or BLANK.
REQ-014 wrap  output  1  one-cycle pulse when digit_idx goes NUM_DIGITS-1 -> 0.

Function
REQ-015 States IDLE, SHOW, BLANK, PAUSED; all outputs registered, updated one cycle after the causing input.
REQ-016 Input priority per cycle: stop > start > step > tick.
REQ-017 IDLE: seg_n = 7'h7F, digit_idx = 0; start -> SHOW, hold_cnt = 0; tick/step ignored.
REQ-018 SHOW: seg_n = decode(bcd); each tick increments hold_cnt; tick with hold_cnt == HOLD_TICKS-1 -> BLANK, hold_cnt = 0.
REQ-019 BLANK: seg_n = 7'h7F; tick -> advance digit_idx, -> SHOW, hold_cnt = 0.
REQ-020 Advance: digit_idx + 1, except NUM_DIGITS-1 -> 0 with wrap = 1 for exactly that cycle; wrap = 0 otherwise.
REQ-021 stop in SHOW or BLANK -> PAUSED; digit_idx kept, hold_cnt cleared; a tick in the same cycle is discarded.
REQ-022 PAUSED: seg_n = decode(bcd); step advances digit_idx (wrap rules apply), stays PAUSED; tick ignored; start (stop low) -> SHOW, hold_cnt = 0.
REQ-023 stop and start both high: stop wins, state remains/enters PAUSED (IDLE stays IDLE).
REQ-024 start while already in SHOW or BLANK: no effect.
REQ-025 bcd = ID_BCD[4*(NUM_DIGITS-1-digit_idx) +: 4], valid in every state.
REQ-026 Decode 0..9 standard active-low (0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10); nibbles A..F show dash 7'h3F.
REQ-027 hold_cnt 4 bits, never exceeds HOLD_TICKS-1.

Reset
REQ-028 Reset asserted: state IDLE, digit_idx 0, hold_cnt 0, seg_n 7'h7F, running 0, wrap 0, immediately without clk.
REQ-029 Reset mid-sequence abandons the sequence; after release the block waits for start.
REQ-030 tick, start, step during Reset have no effect.

Verification
REQ-031 Reset, start, then 2 ticks -> seg_n 7'h79 (digit 1) until second tick, then 7'h7F; next tick -> digit_idx 1, seg_n 7'h24.
REQ-032 Run 24 ticks from start -> wrap pulses one cycle as digit_idx 7 -> 0, running stays 1.
REQ-033 stop with coincident tick at digit_idx 3 -> PAUSED, digit_idx 3, seg_n 7'h19; then 3 step pulses -> digit_idx 6; tick ignored.
REQ-034 In PAUSED at idx 7, step -> digit_idx 0 with wrap 1; start+stop together -> stays PAUSED.
REQ-035 ID_BCD nibble 4'hB at idx 0 -> seg_n 7'h3F in SHOW.
REQ-036 Reset asserted asynchronously in BLANK at idx 5 -> outputs per REQ-028 before next clk edge; ticks after release ignored until start.

Source files
------------

// File: rtl/id_digit_sequencer.sv
// id_digit_sequencer
// Steps through a fixed ID number one digit at a time on a single
// seven-segment display. The 1 s tick sets the pace. Each digit is lit
// for HOLD_TICKS ticks and then blanked for one tick, so that repeated
// digits can be told apart. The user can pause the sequence with stop,
// step through digits by hand with step, and resume with start.
//
// Ports
//   clk        system clock, all state on the rising edge
//   Reset      asynchronous, active-high, clears all state
//   tick       one-cycle pulse from the 1 s rollover timer
//   start      level: begin or resume sequencing
//   stop       level: pause sequencing (has priority over start)
//   step       one-cycle pulse: manual advance while paused
//   digit_idx  index of the current digit (0 = leftmost ID digit)
//   bcd        nibble of the current digit
//   seg_n      active-low segments {g,f,e,d,c,b,a}
//   running    high while in SHOW or BLANK
//   wrap       one-cycle pulse when digit_idx goes from last to 0
module id_digit_sequencer #(
    parameter int                      NUM_DIGITS = 8,
    parameter logic [4*NUM_DIGITS-1:0] ID_BCD     = 32'h12345678,
    parameter int                      HOLD_TICKS = 2
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    output logic [3:0] digit_idx,
    output logic [3:0] bcd,
    output logic [6:0] seg_n,
    output logic       running,
    output logic       wrap
);

    localparam logic [3:0] LAST_IDX  = 4'(NUM_DIGITS - 1);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_TICKS - 1);
    localparam logic [3:0] FIRST_BCD = ID_BCD[4*NUM_DIGITS-1 -: 4];
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK, PAUSED} state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] idx_next;
    logic [3:0] hold_cnt;
    logic [3:0] hold_next;
    logic       wrap_next;
    logic [3:0] bcd_next;
    logic [6:0] seg_next;
    logic [4*NUM_DIGITS-1:0] id_shifted;

    // Active-low decode. Non-decimal nibbles show a dash (segment g only).
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // Next-state logic. The input priority is stop > start > step > tick.
    // When start arrives while the sequence is already running, it has no
    // effect. Ticks are still honoured in that case, so a start level that
    // is held high does not freeze the display.
    always_comb begin
        state_next = state;
        idx_next   = digit_idx;
        hold_next  = hold_cnt;
        wrap_next  = 1'b0;
        case (state)
            IDLE: begin
                if (!stop && start) begin
                    state_next = SHOW;
                    hold_next  = 4'd0;
                end
            end
            SHOW: begin
                if (stop) begin
                    state_next = PAUSED;
                    hold_next  = 4'd0;
                end else if (tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = BLANK;
                        hold_next  = 4'd0;
                    end else begin
                        hold_next = hold_cnt + 4'd1;
                    end
                end
            end
            BLANK: begin
                if (stop) begin
                    state_next = PAUSED;
                    hold_next  = 4'd0;
                end else if (tick) begin
                    state_next = SHOW;
                    hold_next  = 4'd0;
                    wrap_next  = (digit_idx == LAST_IDX);
                    idx_next   = (digit_idx == LAST_IDX) ? 4'd0 : digit_idx + 4'd1;
                end
            end
            PAUSED: begin
                hold_next = 4'd0;
                if (!stop) begin
                    if (start) begin
                        state_next = SHOW;
                    end else if (step) begin
                        wrap_next = (digit_idx == LAST_IDX);
                        idx_next  = (digit_idx == LAST_IDX) ? 4'd0 : digit_idx + 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 4'd0;
                hold_next  = 4'd0;
            end
        endcase
    end

    // The display outputs are computed from the next state, so the
    // registered outputs change on the same edge as the state does.
    // Digit 0 is the most-significant nibble of ID_BCD.
    always_comb begin
        id_shifted = ID_BCD >> (4 * (NUM_DIGITS - 1 - int'(idx_next)));
        bcd_next   = id_shifted[3:0];
        seg_next   = decode(bcd_next);
        if (state_next == IDLE || state_next == BLANK) begin
            seg_next = SEG_OFF;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            digit_idx <= 4'd0;
            hold_cnt  <= 4'd0;
            bcd       <= FIRST_BCD;
            seg_n     <= SEG_OFF;
            running   <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_next;
            digit_idx <= idx_next;
            hold_cnt  <= hold_next;
            bcd       <= bcd_next;
            seg_n     <= seg_next;
            running   <= (state_next == SHOW) || (state_next == BLANK);
            wrap      <= wrap_next;
        end
    end

endmodule

// File: tb/tb_id_digit_sequencer.sv
// tb_id_digit_sequencer
// Scoreboard bench for id_digit_sequencer. The stimulus process drives the
// inputs at the falling edge and advances a reference model. The model
// describes the sequence as a position in a tick timeline: phase 0 up to
// HOLD-1 means the digit is lit, and phase HOLD means it is blanked. The
// expected outputs are queued. After the next rising edge, a monitor pops
// the queue and compares the outputs. A second instance uses an ID that
// contains non-decimal nibbles, so the dash decode is exercised as well.
module tb_id_digit_sequencer;

    localparam int          N    = 8;
    localparam int          HOLD = 2;
    localparam logic [31:0] ID1  = 32'h12345678;
    localparam logic [31:0] ID2  = 32'hB0AF9C3E;
    localparam logic [6:0]  SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    typedef struct {
        logic [3:0] idx;
        logic [3:0] bcd;
        logic [6:0] seg;
        logic       run;
        logic       wrp;
        logic [3:0] bcd2;
        logic [6:0] seg2;
    } exp_t;

    logic       clk;
    logic       Reset;
    logic       tick;
    logic       start;
    logic       stop;
    logic       step;
    logic [3:0] digit_idx;
    logic [3:0] bcd;
    logic [6:0] seg_n;
    logic       running;
    logic       wrap;
    logic [3:0] digit_idx2;
    logic [3:0] bcd2;
    logic [6:0] seg_n2;
    logic       running2;
    logic       wrap2;

    exp_t expQ[$];
    exp_t monE;
    int   nChecks = 0;
    int   nFails  = 0;

    bit mActive;
    bit mPaused;
    int mIdx;
    int mPhase;
    bit mWrap;

    id_digit_sequencer #(.NUM_DIGITS(N), .ID_BCD(ID1), .HOLD_TICKS(HOLD)) dut (
        .clk(clk), .Reset(Reset), .tick(tick), .start(start), .stop(stop), .step(step),
        .digit_idx(digit_idx), .bcd(bcd), .seg_n(seg_n), .running(running), .wrap(wrap)
    );

    id_digit_sequencer #(.NUM_DIGITS(N), .ID_BCD(ID2), .HOLD_TICKS(HOLD)) dut2 (
        .clk(clk), .Reset(Reset), .tick(tick), .start(start), .stop(stop), .step(step),
        .digit_idx(digit_idx2), .bcd(bcd2), .seg_n(seg_n2), .running(running2), .wrap(wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] nibbleOf(input logic [31:0] id, input int i);
        logic [31:0] s;
        s = id >> (4 * (N - 1 - i));
        return s[3:0];
    endfunction

    function automatic void advanceModel();
        mWrap = (mIdx == N - 1);
        mIdx  = (mIdx + 1) % N;
    endfunction

    // One clock cycle of the reference behaviour, with priority stop > start > step > tick.
    function automatic void modelStep(input bit r, input bit sta, input bit sto,
                                      input bit ste, input bit tk);
        mWrap = 1'b0;
        if (r) begin
            mActive = 0; mPaused = 0; mIdx = 0; mPhase = 0;
        end else if (mActive) begin
            if (sto) begin
                mActive = 0; mPaused = 1; mPhase = 0;
            end else if (tk) begin
                if (mPhase == HOLD) begin
                    advanceModel();
                    mPhase = 0;
                end else begin
                    mPhase++;
                end
            end
        end else if (mPaused) begin
            if (!sto) begin
                if (sta) begin
                    mActive = 1; mPaused = 0; mPhase = 0;
                end else if (ste) begin
                    advanceModel();
                end
            end
        end else if (!sto && sta) begin
            mActive = 1; mPhase = 0;
        end
    endfunction

    function automatic exp_t expected();
        exp_t e;
        bit   dark;
        dark   = (!mActive && !mPaused) || (mActive && mPhase == HOLD);
        e.idx  = 4'(mIdx);
        e.bcd  = nibbleOf(ID1, mIdx);
        e.bcd2 = nibbleOf(ID2, mIdx);
        e.seg  = dark ? 7'h7F : SEG[e.bcd];
        e.seg2 = dark ? 7'h7F : SEG[e.bcd2];
        e.run  = mActive;
        e.wrp  = mWrap;
        return e;
    endfunction

    task automatic applyStimulus(input bit r, input bit sta, input bit sto,
                                 input bit ste, input bit tk);
        @(negedge clk);
        Reset = r; start = sta; stop = sto; step = ste; tick = tk;
        modelStep(r, sta, sto, ste, tk);
        expQ.push_back(expected());
    endtask

    task automatic checkOutput(input exp_t e);
        nChecks++;
        if (digit_idx !== e.idx || bcd !== e.bcd || seg_n !== e.seg || running !== e.run ||
            wrap !== e.wrp || bcd2 !== e.bcd2 || seg_n2 !== e.seg2 || digit_idx2 !== e.idx ||
            running2 !== e.run || wrap2 !== e.wrp) begin
            nFails++;
            $display("[TB] FAIL scoreboard t=%0t got idx=%0d bcd=%h seg=%h run=%b wrap=%b bcd2=%h seg2=%h idx2=%0d run2=%b wrap2=%b, expected idx=%0d bcd=%h seg=%h run=%b wrap=%b bcd2=%h seg2=%h",
                     $time, digit_idx, bcd, seg_n, running, wrap, bcd2, seg_n2, digit_idx2,
                     running2, wrap2, e.idx, e.bcd, e.seg, e.run, e.wrp, e.bcd2, e.seg2);
        end
    endtask

    // Reset is raised between clock edges. The outputs must clear before
    // the next edge arrives.
    task automatic asyncResetCheck();
        @(posedge clk);
        #3;
        Reset = 1'b1;
        #1;
        nChecks++;
        if (digit_idx !== 4'd0 || seg_n !== 7'h7F || running !== 1'b0 || wrap !== 1'b0 ||
            bcd !== nibbleOf(ID1, 0) || seg_n2 !== 7'h7F || running2 !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL async_reset got idx=%0d seg=%h run=%b wrap=%b bcd=%h seg2=%h, expected idx=0 seg=7f run=0 wrap=0 bcd=%h seg2=7f",
                     digit_idx, seg_n, running, wrap, bcd, seg_n2, nibbleOf(ID1, 0));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                monE = expQ.pop_front();
                checkOutput(monE);
            end
        end
    end

    initial begin
        int guard;
        int drain;
        Reset = 1'b1; tick = 0; start = 0; stop = 0; step = 0;
        mActive = 0; mPaused = 0; mIdx = 0; mPhase = 0; mWrap = 0;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 1);
        // Idle: ticks and steps must be ignored. Stop together with start keeps the block idle.
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        // Start, then the first digit passes through SHOW, BLANK and on to the next digit.
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1);
            applyStimulus(0, 0, 0, 0, 0);
        end
        // The remaining 21 ticks complete a full lap, so wrap pulses on the last one.
        for (int i = 0; i < 21; i++) begin
            applyStimulus(0, 0, 0, 0, 1);
            applyStimulus(0, 1, 0, 1, 0);
        end
        // Run to digit 3, then pause with a tick in the same cycle.
        guard = 0;
        while (mIdx != 3 && guard < 100) begin
            applyStimulus(0, 0, 0, 0, 1);
            guard++;
        end
        applyStimulus(0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        // Run to BLANK at digit 5, then reset asynchronously.
        guard = 0;
        while (!(mIdx == 5 && mPhase == HOLD) && guard < 100) begin
            applyStimulus(0, 0, 0, 0, 1);
            guard++;
        end
        asyncResetCheck();
        applyStimulus(1, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);

        // Random phase.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 99) < 12,
                          $urandom_range(0, 99) < 8,
                          $urandom_range(0, 99) < 20,
                          $urandom_range(0, 99) < 40);
        end

        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(posedge clk);
            #2;
            drain++;
        end
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL drain got %0d pending, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
